conv5x5_window: RTL

- Downstream stage of the five-line BRAM delay block in the HDMI convolution filter path.
- Consumes the five vertically aligned 8-bit pixels (pa..pe) and the delayed status each clock.
- Builds a 5x5 pixel window and applies a programmable 5x5 signed-coefficient convolution.
- Outputs one saturated 8-bit pixel per clock, with the status delayed to match.

---
 rtl/conv5x5_window_if.sv | 31 +++
 rtl/conv5x5_window.sv | 91 +++++++++
 2 files changed

// File: rtl/conv5x5_window_if.sv
// Pixel, status and coefficient-write bundle for the 5x5 window stage.
// The DUT side is the slave modport.
interface conv5x5_window_if #(
  parameter int STAT_W = 1
);
  logic [7:0]        pa;
  logic [7:0]        pb;
  logic [7:0]        pc;
  logic [7:0]        pd;
  logic [7:0]        pe;
  logic [STAT_W-1:0] stat_in;
  logic              coef_we;
  logic [4:0]        coef_addr;
  logic [7:0]        coef_data;
  logic [7:0]        pix_o;
  logic [STAT_W-1:0] stat_o;

  modport master (
    output pa, pb, pc, pd, pe,
    output stat_in,
    output coef_we, coef_addr, coef_data,
    input  pix_o, stat_o
  );

  modport slave (
    input  pa, pb, pc, pd, pe,
    input  stat_in,
    input  coef_we, coef_addr, coef_data,
    output pix_o, stat_o
  );
endinterface

// File: rtl/conv5x5_window.sv
// 5x5 window and programmable signed convolution behind the line delays.
// One saturated pixel per clock; status delayed to match the pixel path.
module conv5x5_window #(
  parameter int SHIFT  = 4,
  parameter int STAT_W = 1
) (
  input logic            clk,
  input logic            rst,
  conv5x5_window_if.slave bus
);

  logic [7:0]        col   [5];
  logic [7:0]        w     [5][5];
  logic signed [7:0] coef  [25];
  logic signed [16:0] prod [5][5];
  logic signed [19:0] rsum   [5];
  logic signed [19:0] rsum_n [5];
  logic signed [21:0] tot;
  logic signed [21:0] tot_n;
  logic signed [21:0] shf;
  logic [7:0]        pix_q;
  logic [7:0]        pix_n;
  logic [STAT_W-1:0] stat_q [7];

  assign col[0] = bus.pa;
  assign col[1] = bus.pb;
  assign col[2] = bus.pc;
  assign col[3] = bus.pd;
  assign col[4] = bus.pe;

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      rsum_n[r] = '0;
      for (int k = 0; k < 5; k++)
        rsum_n[r] = rsum_n[r] + 20'(prod[r][k]);
    end
    tot_n = '0;
    for (int r = 0; r < 5; r++)
      tot_n = tot_n + 22'(rsum[r]);
  end

  // floor shift, then clamp to 0..255
  always_comb begin
    shf = tot >>> SHIFT;
    pix_n = shf[7:0];
    if (shf[21])
      pix_n = 8'h00;
    else if (shf > 22'sd255)
      pix_n = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 5; r++) begin
        rsum[r] <= '0;
        for (int k = 0; k < 5; k++) begin
          w[r][k]    <= '0;
          prod[r][k] <= '0;
        end
      end
      for (int i = 0; i < 25; i++)
        coef[i] <= (i == 12) ? 8'sd16 : 8'sd0;
      for (int i = 0; i < 7; i++)
        stat_q[i] <= '0;
      tot   <= '0;
      pix_q <= '0;
    end else begin
      for (int r = 0; r < 5; r++) begin
        w[r][0] <= col[r];
        for (int k = 1; k < 5; k++)
          w[r][k] <= w[r][k-1];
        for (int k = 0; k < 5; k++)
          prod[r][k] <= $signed({9'd0, w[r][k]}) *
                        $signed({{9{coef[r*5+k][7]}}, coef[r*5+k]});
        rsum[r] <= rsum_n[r];
      end
      tot   <= tot_n;
      pix_q <= pix_n;
      // seven stages: same edge count as pc through column 2 to pix_o
      stat_q[0] <= bus.stat_in;
      for (int i = 1; i < 7; i++)
        stat_q[i] <= stat_q[i-1];
      if (bus.coef_we && bus.coef_addr < 5'd25)
        coef[bus.coef_addr] <= $signed(bus.coef_data);
    end
  end

  assign bus.pix_o  = pix_q;
  assign bus.stat_o = stat_q[6];

endmodule
